// File: rtl/proximity_event_filter.sv
// Debounces the raw object_detected level into a presence level and issues one
// req/ack approach event per rise, with a cooldown window and a saturating counter.
module proximity_event_filter #(
    parameter int CLOCK_FREQ     = 50000000,
    parameter int SAMPLE_DIV     = 50000,
    parameter int STABLE_SAMPLES = 8,
    parameter int COOLDOWN_TICKS = 2000,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             object_detected,
    input  logic             event_ack,
    output logic             presence,
    output logic             event_req,
    output logic [CNT_W-1:0] approach_count,
    output logic             cooldown_busy
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int ST_W  = $clog2(STABLE_SAMPLES + 1);
    localparam int CD_W  = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(STABLE_SAMPLES - 1);
    localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COOLDOWN_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    if (SAMPLE_DIV < 2 || STABLE_SAMPLES < 1 || CLOCK_FREQ < SAMPLE_DIV) begin : g_bad_params
        $error("proximity_event_filter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        CONFIRM_ON  = 2'd1,
        PRESENT     = 2'd2,
        CONFIRM_OFF = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [ST_W-1:0]    stable_q, stable_d;
    logic               presence_q, presence_d;
    logic [CD_W-1:0]    cooldown_q, cooldown_d;
    logic               event_req_q, event_req_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic tick;
    logic disagree;
    logic rise;
    logic qualified;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            div_q       <= '0;
            stable_q    <= '0;
            presence_q  <= 1'b0;
            cooldown_q  <= '0;
            event_req_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            div_q       <= div_d;
            stable_q    <= stable_d;
            presence_q  <= presence_d;
            cooldown_q  <= cooldown_d;
            event_req_q <= event_req_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        sync1_d  = object_detected;
        sync2_d  = sync1_q;
        tick     = (div_q == DIV_LAST);
        div_d    = tick ? '0 : div_q + DIV_W'(1);
        disagree = (sync2_q != presence_q);
        state_d  = state_q;
        stable_d = stable_q;
        rise     = 1'b0;

        // The stable counter tracks consecutive disagreeing ticks; any agreement rejects the glitch.
        if (tick) begin
            case (state_q)
                IDLE, CONFIRM_ON: begin
                    if (!disagree) begin
                        state_d  = IDLE;
                        stable_d = '0;
                    end else if (stable_q == ST_LAST) begin
                        state_d  = PRESENT;
                        stable_d = '0;
                        rise     = 1'b1;
                    end else begin
                        state_d  = CONFIRM_ON;
                        stable_d = stable_q + ST_W'(1);
                    end
                end
                default: begin
                    if (!disagree) begin
                        state_d  = PRESENT;
                        stable_d = '0;
                    end else if (stable_q == ST_LAST) begin
                        state_d  = IDLE;
                        stable_d = '0;
                    end else begin
                        state_d  = CONFIRM_OFF;
                        stable_d = stable_q + ST_W'(1);
                    end
                end
            endcase
        end

        presence_d = (state_d == PRESENT) || (state_d == CONFIRM_OFF);
        qualified  = rise && (cooldown_q == '0);

        cooldown_d = cooldown_q;
        if (qualified) begin
            cooldown_d = CD_LOAD;
        end else if (tick && cooldown_q != '0) begin
            cooldown_d = cooldown_q - CD_W'(1);
        end

        // A new event in the same cycle as an ack wins, so set comes after clear.
        event_req_d = event_req_q;
        if (event_ack && event_req_q) begin
            event_req_d = 1'b0;
        end
        if (qualified) begin
            event_req_d = 1'b1;
        end

        count_d = count_q;
        if (qualified && count_q != CNT_MAX) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign presence       = presence_q;
    assign event_req      = event_req_q;
    assign approach_count = count_q;
    assign cooldown_busy  = (cooldown_q != '0);

endmodule

// File: tb/tb_proximity_event_filter.sv
// Directed bench for proximity_event_filter: approach counts are scoreboarded,
// everything else is checked inline with immediate assertions.
module tb_proximity_event_filter;

    localparam int SD = 4;
    localparam int SS = 3;
    localparam int CD = 5;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          obj = 1'b0;
    logic          ack = 1'b0;
    logic          presence, event_req, cooldown_busy;
    logic [CW-1:0] approach_count;

    // Second instance with a long cooldown, used to exercise suppression.
    logic          rst2 = 1'b1;
    logic          obj2 = 1'b0;
    logic          ack2 = 1'b0;
    logic          presence2, event_req2, cooldown_busy2;
    logic [CW-1:0] approach_count2;

    int            checks = 0;
    int            errors = 0;
    int            ecnt;
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] prev_cnt = '0;

    always #5 clk = ~clk;

    proximity_event_filter #(
        .SAMPLE_DIV(SD), .STABLE_SAMPLES(SS), .COOLDOWN_TICKS(CD), .CNT_W(CW)
    ) u_dut (
        .clk(clk), .rst(rst), .object_detected(obj), .event_ack(ack),
        .presence(presence), .event_req(event_req),
        .approach_count(approach_count), .cooldown_busy(cooldown_busy)
    );

    proximity_event_filter #(
        .SAMPLE_DIV(SD), .STABLE_SAMPLES(SS), .COOLDOWN_TICKS(12), .CNT_W(CW)
    ) u_dut2 (
        .clk(clk), .rst(rst2), .object_detected(obj2), .event_ack(ack2),
        .presence(presence2), .event_req(event_req2),
        .approach_count(approach_count2), .cooldown_busy(cooldown_busy2)
    );

    // Edges since the last reset release; the sample tick lands on index 3 mod 4.
    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next sampling point and pop the scoreboard on any count change.
    task automatic step();
        @(negedge clk);
        if (rst) begin
            prev_cnt = '0;
        end else if (approach_count !== prev_cnt) begin
            if (exp_q.size() == 0) chk("sb unexpected count", 32'(approach_count), 32'(prev_cnt));
            else                   chk("sb count", 32'(approach_count), 32'(exp_q.pop_front()));
            prev_cnt = approach_count;
        end
    endtask

    task automatic wait_pres(input bit sel, input logic val, input int budget,
                             input string tag, output int n);
        n = 0;
        while (((sel ? presence2 : presence) !== val) && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(sel ? presence2 : presence), 32'(val));
    endtask

    task automatic wait_idle(input bit sel, input int budget, input string tag);
        int n = 0;
        while ((sel ? cooldown_busy2 : cooldown_busy) && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(sel ? cooldown_busy2 : cooldown_busy), 0);
    endtask

    initial begin
        int   n, nb, p, t, rise_e;
        logic seen;

        // Reset values, object already present
        obj = 1'b1;
        repeat (3) step();
        chk("reset presence", 32'(presence), 0);
        chk("reset event_req", 32'(event_req), 0);
        chk("reset count", 32'(approach_count), 0);
        chk("reset busy", 32'(cooldown_busy), 0);

        // Held object from reset release: first event after sync + 3 ticks
        exp_q.push_back(CW'(1));
        rst = 1'b0;
        wait_pres(0, 1'b1, 20, "t1 presence rise", n);
        chk("t1 rise latency clk", n, 12);
        chk("t1 event_req", 32'(event_req), 1);
        chk("t1 count", 32'(approach_count), 1);
        nb = 0;
        while (cooldown_busy && nb < 40) begin
            nb++;
            step();
        end
        chk("t1 busy clk", nb, 20);

        // Ack clears next clk; ack without request is ignored
        chk("t3 req pending", 32'(event_req), 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t3 req cleared", 32'(event_req), 0);
        ack = 1'b1;
        repeat (2) step();
        ack = 1'b0;
        chk("t3 idle ack req", 32'(event_req), 0);
        chk("t3 idle ack count", 32'(approach_count), 1);

        // Falling presence issues no event
        obj = 1'b0;
        wait_pres(0, 1'b0, 14, "fall presence", n);
        chk("fall event_req", 32'(event_req), 0);
        chk("fall count", 32'(approach_count), 1);

        // 1-tick and 2-tick glitches are rejected
        for (int w = 1; w <= 2; w++) begin
            seen = 1'b0;
            obj  = 1'b1;
            repeat (4 * w) begin
                step();
                seen = seen | presence | event_req;
            end
            obj = 1'b0;
            repeat (24) begin
                step();
                seen = seen | presence | event_req;
            end
            chk("t2 glitch seen", 32'(seen), 0);
            chk("t2 glitch count", 32'(approach_count), 1);
        end

        // Approach after cooldown, acked 3 clk after the request
        exp_q.push_back(CW'(2));
        obj = 1'b1;
        wait_pres(0, 1'b1, 14, "t3 rise", n);
        chk("t3 event_req", 32'(event_req), 1);
        chk("t3 busy", 32'(cooldown_busy), 1);
        repeat (3) step();
        chk("t3 req held", 32'(event_req), 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t3 req after ack", 32'(event_req), 0);
        chk("t3 count", 32'(approach_count), 2);

        // Away and back inside a long cooldown: no event; again after expiry: event
        obj2 = 1'b1;
        step();
        rst2 = 1'b0;
        wait_pres(1, 1'b1, 20, "t4 first rise", n);
        chk("t4 first latency", n, 12);
        chk("t4 first req", 32'(event_req2), 1);
        chk("t4 first count", 32'(approach_count2), 1);
        ack2 = 1'b1;
        step();
        ack2 = 1'b0;
        chk("t4 req acked", 32'(event_req2), 0);
        obj2 = 1'b0;
        wait_pres(1, 1'b0, 14, "t4 away", n);
        obj2 = 1'b1;
        wait_pres(1, 1'b1, 14, "t4 back", n);
        chk("t4 suppressed req", 32'(event_req2), 0);
        chk("t4 suppressed count", 32'(approach_count2), 1);
        chk("t4 still busy", 32'(cooldown_busy2), 1);
        wait_idle(1, 60, "t4 cooldown expiry");
        obj2 = 1'b0;
        wait_pres(1, 1'b0, 14, "t4 away2", n);
        obj2 = 1'b1;
        wait_pres(1, 1'b1, 14, "t4 back2", n);
        chk("t4 new req", 32'(event_req2), 1);
        chk("t4 new count", 32'(approach_count2), 2);

        // Spaced approaches without ack: count saturates, req stays high
        obj = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(CW'(k));
            obj = 1'b1;
            wait_pres(0, 1'b1, 14, "t5 rise", n);
            chk("t5 req", 32'(event_req), 1);
            chk("t5 count", 32'(approach_count), k);
            obj = 1'b0;
            wait_pres(0, 1'b0, 14, "t5 fall", n);
            wait_idle(0, 40, "t5 cooldown expiry");
        end
        // Fourth approach with ack landing on the rise edge
        obj = 1'b1;
        p = ecnt;
        t = p + 2;
        while (t % SD != SD - 1) t++;
        rise_e = t + (SS - 1) * SD;
        n = 0;
        while (ecnt < rise_e && n < 40) begin
            step();
            n++;
        end
        chk("t5 pre-rise presence", 32'(presence), 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t5 same-clk presence", 32'(presence), 1);
        chk("t5 same-clk req", 32'(event_req), 1);
        chk("t5 saturated count", 32'(approach_count), 3);
        chk("t5 cooldown reload", 32'(cooldown_busy), 1);

        // Async reset mid-operation, then a fresh event after full debounce
        #2 rst = 1'b1;
        #1;
        chk("t6 async presence", 32'(presence), 0);
        chk("t6 async req", 32'(event_req), 0);
        chk("t6 async count", 32'(approach_count), 0);
        chk("t6 async busy", 32'(cooldown_busy), 0);
        repeat (2) step();
        exp_q.push_back(CW'(1));
        rst = 1'b0;
        wait_pres(0, 1'b1, 20, "t6 rise", n);
        chk("t6 rise latency clk", n, 12);
        chk("t6 req", 32'(event_req), 1);
        step();
        chk("sb drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
